// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD display path.
// Holds the SPI receiver state type, frame size and ASCII range bounds.
package lcd_pkg;

  typedef enum logic [1:0] {
    rx_idle    = 2'd0,
    rx_receive = 2'd1,
    rx_check   = 2'd2
  } spi_rx_statetype;

  localparam int SPI_FRAME_BITS = 16;

  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;
  localparam logic [7:0] ASCII_DIGIT_MIN = 8'h30;
  localparam logic [7:0] ASCII_DIGIT_MAX = 8'h39;

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic is_print(input logic [7:0] v);
    return in_range(v, ASCII_PRINT_MIN, ASCII_PRINT_MAX);
  endfunction

  function automatic logic is_digit(input logic [7:0] v);
    return in_range(v, ASCII_DIGIT_MIN, ASCII_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/spi_char_receiver_sync_edge.sv
// N-flop synchronizer with configurable reset value, producing the synchronized
// level plus one-cycle rise/fall strobes.
module sync_edge #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;
  logic [N:0]   fill_q;
  logic         armed;

  // Strobes stay quiet until the chain and prev flop hold real samples, so the
  // reset value can never masquerade as an edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {N{RESET_VAL}};
      prev_q <= RESET_VAL;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
      fill_q <= {fill_q[N-1:0], 1'b1};
    end
  end

  assign armed   = fill_q[N];
  assign level_o = sync_q[N-1];
  assign rise_o  = armed & sync_q[N-1] & ~prev_q;
  assign fall_o  = armed & ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_char_receiver.sv
// Two-byte SPI (mode 0) frame receiver feeding the LCD controller: letter, number.
// Optional printable/digit filter enabled by defining SPI_CHAR_FILTER_EN.
module spi_char_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic [7:0] letter,
  output logic [7:0] number,
  output logic       new_SPI,
  output logic       frame_err,
  output logic [4:0] rx_dbg_o
);

  localparam logic [4:0] FRAME_CNT = 5'(SPI_FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_rx_statetype state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  letter_q, letter_d;
  logic [7:0]  number_q, number_d;
  logic        new_q, new_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        filter_ok;
  logic        frame_ok;

  sync_edge #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .rst_n   (reset),
    .d_i     (sck),
    .level_o (sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  sync_edge #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (reset),
    .d_i     (cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // Same depth as the sck level path so mosi_s is the value present at the sck rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_CHAR_FILTER_EN
  assign filter_ok = is_print(shreg_q[15:8]) && is_digit(shreg_q[7:0]);
`else
  assign filter_ok = 1'b1;
`endif

  assign frame_ok = (cnt_q == FRAME_CNT) && filter_ok;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    letter_d = letter_q;
    number_d = number_q;
    pend_d   = pend_q;
    new_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      rx_idle: begin
        pend_d = 1'b0;
        if (cs_fall || pend_q) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = rx_receive;
        end
      end
      rx_receive: begin
        // A shift coinciding with cs_n rise still lands before CHECK evaluates.
        if (sck_rise) begin
          shreg_d = {shreg_q[14:0], mosi_s};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
        end
        if (cs_rise) state_d = rx_check;
      end
      rx_check: begin
        state_d = rx_idle;
        if (cs_fall) pend_d = 1'b1;
        if (frame_ok) begin
          letter_d = shreg_q[15:8];
          number_d = shreg_q[7:0];
          new_d    = 1'b1;
        end else begin
          err_d    = 1'b1;
        end
      end
      default: state_d = rx_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= rx_idle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      letter_q <= '0;
      number_q <= '0;
      new_q    <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      letter_q <= letter_d;
      number_q <= number_d;
      new_q    <= new_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end
  end

  assign letter    = letter_q;
  assign number    = number_q;
  assign new_SPI   = new_q;
  assign frame_err = err_q;
  assign rx_dbg_o  = {2'(state_q), cs_lvl, sck_lvl, sck_fall};

endmodule
